// File: rtl/seq_fixdiv_pkg.sv
// Shared types and sizing helpers for the iterative fixed-point divider.
package seq_fixdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of restoring steps: one per result bit, plus a guard bit when rounding.
    function automatic int iter_count(input int width, input int frac, input bit round);
        return width + frac + (round ? 1 : 0);
    endfunction

    function automatic int cnt_width(input int width, input int frac);
        return $clog2(width + frac + 2);
    endfunction

endpackage

// File: rtl/seq_fixdiv_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract den.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] den,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] trial;
    logic [WIDTH+1:0] diff;

    always_comb begin
        trial   = {rem_in, dvd_bit};
        diff    = trial - {2'b00, den};
        q_bit   = (trial >= {2'b00, den});
        rem_out = q_bit ? diff[WIDTH:0] : trial[WIDTH:0];
    end

endmodule

// File: rtl/seq_fixdiv.sv
// Iterative unsigned WIDTH.FRAC divider, one restoring step per clock, valid/ready on both sides.
// Define SEQ_FIXDIV_ROUND_EN for round-half-up via one extra guard-bit iteration.
module seq_fixdiv
    import seq_fixdiv_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] den,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quot,
    output logic [FRAC-1:0]  frac,
    output logic             div_zero
);

`ifdef SEQ_FIXDIV_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif
    localparam int ITER = iter_count(WIDTH, FRAC, ROUND);
    localparam int CW   = cnt_width(WIDTH, FRAC);
    localparam int RW   = WIDTH + FRAC;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [ITER-2:0]  qsh_q, qsh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    res_q, res_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   step_rem;
    logic             step_q;
    logic [ITER-1:0]  q_next;
    logic [RW-1:0]    q_final;

    // Only the numerator is stored; the FRAC (+guard) low dividend bits are zeros shifted in.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .dvd_bit (dvd_q[WIDTH-1]),
        .den     (den_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        q_next = {qsh_q, step_q};
`ifdef SEQ_FIXDIV_ROUND_EN
        q_final = q_next[ITER-1:1] + RW'(q_next[0]);
`else
        q_final = q_next;
`endif
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        den_d   = den_q;
        rem_d   = rem_q;
        qsh_d   = qsh_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d   = num;
                    den_d   = den;
                    rem_d   = '0;
                    qsh_d   = '0;
                    cnt_d   = CW'(ITER);
                    res_d   = '0;
                    dz_d    = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A zero divisor spends exactly one cycle here, so its result lands one edge after accept.
                if (den_q == '0) begin
                    res_d   = '1;
                    dz_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    rem_d = step_rem;
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                    qsh_d = q_next[ITER-2:0];
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        res_d   = q_final;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            den_q   <= '0;
            rem_q   <= '0;
            qsh_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            den_q   <= den_d;
            rem_q   <= rem_d;
            qsh_q   <= qsh_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quot      = res_q[RW-1:FRAC];
    assign frac      = res_q[FRAC-1:0];
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_seq_fixdiv.sv
// Directed + randomized bench for seq_fixdiv against an arithmetic reference model.
module tb_seq_fixdiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] num = '0;
    logic [15:0] den = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] quot;
    logic [15:0] frac;
    logic        div_zero;

`ifdef SEQ_FIXDIV_ROUND_EN
    localparam int LAT = 33;
    localparam bit RND = 1'b1;
`else
    localparam int LAT = 32;
    localparam bit RND = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    seq_fixdiv #(.WIDTH(16), .FRAC(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num       (num),
        .den       (den),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .frac      (frac),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: floor(num*2^16/den), or round-half-up of num*2^16/den; all ones for den==0.
    function automatic logic [31:0] ref_div(input logic [15:0] n, input logic [15:0] d);
        longint q;
        if (d == 16'd0) return 32'hFFFF_FFFF;
        if (RND) begin
            q = (longint'(n) * 131072) / longint'(d);
            q = (q + 1) / 2;
        end else begin
            q = (longint'(n) * 65536) / longint'(d);
        end
        return q[31:0];
    endfunction

    task automatic start(input logic [15:0] n, input logic [15:0] d);
        @(negedge clk);
        check("accept_ready", in_ready, 1'b1);
        num = n;
        den = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("consume_in_ready", in_ready, 1'b1);
        check("consume_out_valid", out_valid, 1'b0);
    endtask

    task automatic run(input string tag, input logic [15:0] n, input logic [15:0] d);
        int c;
        start(n, d);
        wait_done(c);
        check({tag, "_lat"}, c, (d == 16'd0) ? 1 : LAT);
        check({tag, "_res"}, {quot, frac}, ref_div(n, d));
        check({tag, "_dz"}, div_zero, (d == 16'd0));
        consume();
    endtask

    initial begin
        int c;
        logic [32:0] held;

        #12;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", {quot, frac, div_zero}, 33'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("7_2", 16'd7, 16'd2);
        check("7_2_frac", frac, 16'h8000);
        run("2_3", 16'd2, 16'd3);
        check("2_3_frac", frac, RND ? 16'hAAAB : 16'hAAAA);
        run("1_3", 16'd1, 16'd3);
        check("1_3_frac", frac, 16'h5555);
        run("ffff_1", 16'hFFFF, 16'd1);
        run("0_5", 16'd0, 16'd5);
        run("5_0", 16'd5, 16'd0);
        run("ffff_ffff", 16'hFFFF, 16'hFFFF);

        // Back-pressure: result must hold while out_ready stays low.
        start(16'd9, 16'd4);
        wait_done(c);
        held = {quot, frac, div_zero};
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_stable", {quot, frac, div_zero}, {ref_div(16'd9, 16'd4), 1'b0});
            check("bp_held", {quot, frac, div_zero}, held);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
        end
        consume();

        // in_valid pulsed mid-operation must be ignored.
        start(16'd7, 16'd2);
        repeat (5) @(posedge clk);
        @(negedge clk);
        num = 16'd100;
        den = 16'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(c);
        check("ign_res", {quot, frac}, ref_div(16'd7, 16'd2));
        consume();
        repeat (3) @(posedge clk);
        #1 check("ign_idle", {in_ready, out_valid}, 2'b10);

        // Asynchronous reset mid-operation.
        start(16'd1000, 16'd7);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_in_ready", in_ready, 1'b1);
        check("arst_result", {quot, frac, div_zero}, 33'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run("post_rst_1_1", 16'd1, 16'd1);

        for (int i = 0; i < 30; i++) begin
            logic [15:0] rn, rd;
            rn = 16'($urandom);
            rd = (i % 10 == 9) ? 16'd0 : 16'($urandom_range(1, 65535));
            run("rand", rn, rd);
        end

        for (int d = 1; d <= 511; d++) run("sweep", 16'd1, 16'(d));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
